// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch/decode stage and the controller:
// 5-bit opcode values, opcode count, instruction field positions, fetch state.
package isa_pkg;

    localparam int N_OP = 23;

    localparam logic [4:0] OP_MOV       = 5'd0;
    localparam logic [4:0] OP_ADDI      = 5'd1;
    localparam logic [4:0] OP_SUBI      = 5'd2;
    localparam logic [4:0] OP_LHI       = 5'd3;
    localparam logic [4:0] OP_LLI       = 5'd4;
    localparam logic [4:0] OP_LDR       = 5'd5;
    localparam logic [4:0] OP_STR       = 5'd6;
    localparam logic [4:0] OP_ADD       = 5'd7;
    localparam logic [4:0] OP_ADC       = 5'd8;
    localparam logic [4:0] OP_SUB       = 5'd9;
    localparam logic [4:0] OP_SBB       = 5'd10;
    localparam logic [4:0] OP_CMP       = 5'd11;
    localparam logic [4:0] OP_BCC       = 5'd12;
    localparam logic [4:0] OP_BCS       = 5'd13;
    localparam logic [4:0] OP_BNE       = 5'd14;
    localparam logic [4:0] OP_BEQ       = 5'd15;
    localparam logic [4:0] OP_BAL       = 5'd16;
    localparam logic [4:0] OP_JMP       = 5'd17;
    localparam logic [4:0] OP_JAL_LABEL = 5'd18;
    localparam logic [4:0] OP_JAL_RM    = 5'd19;
    localparam logic [4:0] OP_JR        = 5'd20;
    localparam logic [4:0] OP_OUTR      = 5'd21;
    localparam logic [4:0] OP_HLT       = 5'd22;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 11;
    localparam int RD_MSB   = 10;
    localparam int RD_LSB   = 8;
    localparam int RM_MSB   = 7;
    localparam int RM_LSB   = 5;
    localparam int RN_MSB   = 4;
    localparam int RN_LSB   = 2;
    localparam int IMM8_MSB = 7;
    localparam int IMM5_MSB = 4;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/op_decode.sv
// Opcode decoder: 16-bit instruction word to one-hot opcode plus illegal flag.
// Latency: purely combinational. Backpressure: none, no state.
module op_decode
    import isa_pkg::*;
(
    input  logic [15:0]     instr,
    output logic [N_OP-1:0] op_onehot,
    output logic            illegal
);

    logic [4:0] opc;
    logic       unused_fields;

    assign opc           = instr[OPC_MSB:OPC_LSB];
    assign unused_fields = ^instr[OPC_LSB-1:0];

    // Opcodes past HLT decode to an all-zero vector (NOP) and raise illegal.
    always_comb begin
        op_onehot = '0;
        for (int i = 0; i < N_OP; i++) begin
            op_onehot[i] = (opc == 5'(i));
        end
        illegal = (opc > OP_HLT);
    end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: PC, sync imem read, registered decode; FETCH_ILLEGAL_TRAP_EN traps illegal ops.
// Latency: 2 edges from issue (or redirect/resume) to out_valid; 1 instruction/cycle.
// Backpressure: out_valid & ~out_ready freezes PC, pending read and outputs; imem_en drops.
module fetch_decode #(
    parameter int PC_W = 8,
    parameter int N_OP = 23
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N_OP-1:0] op_onehot,
    output logic [2:0]      rd,
    output logic [2:0]      rm,
    output logic [2:0]      rn,
    output logic [7:0]      imm8,
    output logic [4:0]      imm5,
    output logic [PC_W-1:0] out_pc,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            resume,
    output logic            halted,
    output logic            illegal_op
);
    import isa_pkg::*;

`ifdef FETCH_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    fetch_state_t    state, state_d;
    logic [PC_W-1:0] pc_q;
    logic            pending;
    logic [N_OP-1:0] dec_onehot;
    logic            dec_illegal;
    logic            stall, load, issue, halt_req;

    op_decode u_op_decode (
        .instr     (imem_rdata),
        .op_onehot (dec_onehot),
        .illegal   (dec_illegal)
    );

    always_comb begin
        stall    = out_valid & ~out_ready;
        load     = pending & ~stall & ~redirect_valid;
        halt_req = load & (dec_onehot[OP_HLT] | (TRAP_EN & dec_illegal));
        issue    = (state == ST_RUN) & ~stall & ~redirect_valid;
        state_d  = state;
        if (redirect_valid) begin
            state_d = ST_RUN;
        end else if (halt_req) begin
            state_d = ST_HALT;
        end else if (state == ST_HALT && resume) begin
            state_d = ST_RUN;
        end
    end

    assign imem_en   = issue & ~rst;
    assign imem_addr = pc_q;
    assign halted    = (state == ST_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_d;
        end
    end

    // A halting load keeps pc_q at HLT+1 and drops the younger read already in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            pending   <= 1'b0;
            out_valid <= 1'b0;
            op_onehot <= '0;
            rd        <= '0;
            rm        <= '0;
            rn        <= '0;
            imm8      <= '0;
            imm5      <= '0;
            out_pc    <= '0;
        end else if (redirect_valid) begin
            pc_q      <= redirect_pc;
            pending   <= 1'b0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_valid <= load;
            pending   <= issue & ~halt_req;
            if (issue && !halt_req) begin
                pc_q <= pc_q + PC_W'(1);
            end
            if (load) begin
                op_onehot <= dec_onehot;
                rd        <= imem_rdata[RD_MSB:RD_LSB];
                rm        <= imem_rdata[RM_MSB:RM_LSB];
                rn        <= imem_rdata[RN_MSB:RN_LSB];
                imm8      <= imem_rdata[IMM8_MSB:0];
                imm5      <= imem_rdata[IMM5_MSB:0];
                out_pc    <= pc_q - PC_W'(1);
            end
        end
    end

`ifdef FETCH_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_op <= 1'b0;
        end else if (redirect_valid) begin
            illegal_op <= 1'b0;
        end else if (load && dec_illegal) begin
            illegal_op <= 1'b1;
        end
    end
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: directed timing scenarios, then randomized traffic vs a program-order model.
module tb_fetch_decode;

    logic        clk;
    logic        rst;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] op_onehot;
    logic [2:0]  rd, rm, rn;
    logic [7:0]  imm8;
    logic [4:0]  imm5;
    logic [7:0]  out_pc;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        resume;
    logic        halted;
    logic        illegal_op;

    logic [15:0] mem [256];
    int          n_chk  = 0;
    int          n_pass = 0;

    fetch_decode #(.PC_W(8), .N_OP(23)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .op_onehot      (op_onehot),
        .rd             (rd),
        .rm             (rm),
        .rn             (rn),
        .imm8           (imm8),
        .imm5           (imm5),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .resume         (resume),
        .halted         (halted),
        .illegal_op     (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: output holds while imem_en is low.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [22:0] exp_op(input logic [15:0] w);
        logic [4:0] o;
        o = w[15:11];
        if (o < 5'd23) return 23'd1 << o;
        return '0;
    endfunction

    function automatic logic [21:0] exp_fld(input logic [15:0] w);
        return {w[10:8], w[7:5], w[4:2], w[7:0], w[4:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pres(input string tag, input logic [7:0] pc);
        chk({tag, ".vld"}, 32'(out_valid), 32'd1);
        chk({tag, ".pc"},  32'(out_pc), 32'(pc));
        chk({tag, ".op"},  32'(op_onehot), 32'(exp_op(mem[pc])));
        chk({tag, ".fld"}, 32'({rd, rm, rn, imm8, imm5}), 32'(exp_fld(mem[pc])));
    endtask

    task automatic redirect_to(input string tag, input logic [7:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        #1;
        chk({tag, ".en"}, 32'(imem_en), 32'd0);
        tick();
        redirect_valid = 1'b0;
        chk({tag, ".bub1"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, ".bub2"}, 32'(out_valid), 32'd0);
        tick();
    endtask

    task automatic do_resume();
        resume = 1'b1;
        tick();
        resume = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [7:0] exp_pc;
        int         idle;
        rst            = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        resume         = 1'b0;
        imem_rdata     = '0;
        for (int i = 0; i < 256; i++) mem[i] = {5'(i % 22), 11'($urandom)};
        mem[0]    = {5'd0,  11'($urandom)};
        mem[1]    = {5'd7,  11'($urandom)};
        mem[2]    = {5'd9,  11'($urandom)};
        mem[3]    = {5'd2,  11'($urandom)};
        mem[4]    = {5'd0,  11'($urandom)};
        mem[5]    = {5'd1,  11'($urandom)};
        mem[8]    = {5'd25, 11'($urandom)};
        mem[8'h10] = {5'd22, 11'($urandom)};
        mem[8'h14] = {5'd22, 11'($urandom)};

        tick();
        tick();
        chk("rst.vld", 32'(out_valid), 32'd0);
        chk("rst.en", 32'(imem_en), 32'd0);
        chk("rst.op", 32'(op_onehot), 32'd0);
        chk("rst.pc", 32'(out_pc), 32'd0);
        chk("rst.halt", 32'({halted, illegal_op}), 32'd0);
        chk("rst.fld", 32'({rd, rm, rn, imm8, imm5}), 32'd0);

        rst = 1'b0;
        #1;
        chk("start.en", 32'(imem_en), 32'd1);
        chk("start.addr", 32'(imem_addr), 32'd0);
        tick();
        chk("start.e1", 32'(out_valid), 32'd0);
        tick();
        check_pres("mov0", 8'd0);
        chk("mov0.onehot", 32'(op_onehot), 32'h1);
        tick();
        check_pres("add1", 8'd1);
        chk("add1.onehot", 32'(op_onehot), 32'h80);
        tick();
        check_pres("sub2", 8'd2);

        out_ready = 1'b0;
        #1;
        chk("stall.en", 32'(imem_en), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall.pc", 32'(out_pc), 32'd2);
            chk("stall.vld", 32'(out_valid), 32'd1);
            chk("stall.en_hold", 32'(imem_en), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check_pres("subi3", 8'd3);
        chk("subi3.onehot", 32'(op_onehot), 32'h4);
        tick();
        check_pres("mov4", 8'd4);
        tick();
        check_pres("addi5", 8'd5);

        redirect_to("redir40", 8'h40);
        check_pres("redir40", 8'h40);

        redirect_to("redir06", 8'h06);
        check_pres("p6", 8'd6);
        tick();
        check_pres("p7", 8'd7);
        tick();
        check_pres("ill8", 8'd8);
`ifdef FETCH_ILLEGAL_TRAP_EN
        chk("ill8.flag", 32'(illegal_op), 32'd1);
        chk("ill8.halt", 32'(halted), 32'd1);
        tick();
        chk("ill8.stop_vld", 32'(out_valid), 32'd0);
        chk("ill8.stop_en", 32'(imem_en), 32'd0);
        do_resume();
        check_pres("ill8.next", 8'd9);
        chk("ill8.sticky", 32'(illegal_op), 32'd1);
`else
        chk("ill8.flag", 32'(illegal_op), 32'd0);
        chk("ill8.halt", 32'(halted), 32'd0);
        tick();
        check_pres("ill8.next", 8'd9);
`endif

        redirect_to("redir10", 8'h10);
        check_pres("hlt10", 8'h10);
        chk("hlt10.halt", 32'(halted), 32'd1);
        chk("hlt10.ill_clr", 32'(illegal_op), 32'd0);
        tick();
        chk("hlt10.vld", 32'(out_valid), 32'd0);
        chk("hlt10.halt2", 32'(halted), 32'd1);
        chk("hlt10.en", 32'(imem_en), 32'd0);
        tick();
        chk("hlt10.idle", 32'(out_valid), 32'd0);
        do_resume();
        check_pres("resume11", 8'h11);
        chk("resume11.halt", 32'(halted), 32'd0);

        redirect_to("redir14", 8'h14);
        check_pres("hlt14", 8'h14);
        chk("hlt14.halt", 32'(halted), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h20;
        tick();
        redirect_valid = 1'b0;
        chk("hlt14.cancel", 32'(halted), 32'd0);
        chk("hlt14.bub", 32'(out_valid), 32'd0);
        tick();
        tick();
        check_pres("redir20", 8'h20);
        tick();
        check_pres("p21", 8'h21);

        rst = 1'b1;
        #1;
        chk("midrst.vld", 32'(out_valid), 32'd0);
        chk("midrst.en", 32'(imem_en), 32'd0);
        chk("midrst.op", 32'(op_onehot), 32'd0);
        chk("midrst.pc", 32'(out_pc), 32'd0);
        chk("midrst.fld", 32'({rd, rm, rn, imm8, imm5}), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst.addr", 32'(imem_addr), 32'd0);
        tick();
        tick();
        check_pres("midrst.p0", 8'd0);

        // Randomized traffic: each accepted instruction must be the next one in program order.
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        exp_pc = 8'd0;
        idle   = 0;
        for (int c = 0; c < 3000; c++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = 8'($urandom);
            resume         = ($urandom_range(0, 6) == 0);
            #1;
            if (out_valid && out_ready) begin
                chk("rand.pc", 32'(out_pc), 32'(exp_pc));
                chk("rand.op", 32'(op_onehot), 32'(exp_op(mem[exp_pc])));
                chk("rand.fld", 32'({rd, rm, rn, imm8, imm5}), 32'(exp_fld(mem[exp_pc])));
`ifdef FETCH_ILLEGAL_TRAP_EN
                if (mem[exp_pc][15:11] > 5'd22) chk("rand.ill", 32'(illegal_op), 32'd1);
`else
                chk("rand.ill", 32'(illegal_op), 32'd0);
`endif
                exp_pc = exp_pc + 8'd1;
                idle   = 0;
            end else begin
                idle++;
            end
            if (redirect_valid) exp_pc = redirect_pc;
            if (idle > 64) begin
                chk("rand.progress", 32'(idle), 32'd0);
                break;
            end
            tick();
        end
        redirect_valid = 1'b0;
        resume         = 1'b0;
        out_ready      = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
